// File: rtl/multicycle_control.sv
// Multicycle control FSM for the RV datapath: fetch/decode/execute/memory/writeback sequencing,
// memory ready handshake with wait timeout, and a sticky trap on unsupported instructions.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_addr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             trap,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_R  = 7'b0110011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    instret_q, instret_d;
    logic                retire_c;
    logic                timeout_c;
    logic                taken_c;
    logic                is_ld_c;

    // A zero MEM_TIMEOUT leaves the handshake waiting forever.
    assign timeout_c = (MEM_TIMEOUT != 0) && !mem_ready && (wait_q == WAIT_W'(MEM_TIMEOUT));
    assign is_ld_c   = (opcode == OP_LD);

    // Next state and all datapath controls; outputs follow the current state combinationally.
    always_comb begin
        state_d      = state_q;
        retire_c     = 1'b0;
        taken_c      = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr_src = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        trap         = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout_c) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                state_d = (opcode inside {OP_LD, OP_SD, OP_BR, OP_R}) ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                case (opcode)
                    OP_LD, OP_SD: begin
                        alu_src_b = 2'b01;
                        state_d   = S_MEM;
                    end
                    OP_R: begin
                        alu_op  = 2'b10;
                        state_d = S_WB;
                    end
                    OP_BR: begin
                        alu_op = 2'b01;
                        if (funct3 == 3'b000 || funct3 == 3'b001) begin
                            taken_c  = (funct3 == 3'b000) ? zero : !zero;
                            pc_write = taken_c;
                            pc_src   = taken_c;
                            retire_c = 1'b1;
                            state_d  = S_FETCH;
                        end else begin
                            state_d = S_TRAP;
                        end
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                mem_addr_src = 1'b1;
                mem_read     = is_ld_c;
                mem_write    = (opcode == OP_SD);
                if (mem_ready) begin
                    state_d  = is_ld_c ? S_WB : S_FETCH;
                    retire_c = !is_ld_c;
                end else if (timeout_c) begin
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_ld_c;
                retire_c   = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: trap = 1'b1;
            default: state_d = S_TRAP;
        endcase
    end

    // Wait counter restarts on every state change, so it is zero on entry to FETCH/MEM.
    always_comb begin
        wait_d    = '0;
        instret_d = instret_q + CNT_W'(retire_c);
        if (state_d == state_q) begin
            wait_d = mem_ready ? wait_q : wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: an instruction-level model expands each instruction
// into its expected per-cycle control vectors; a monitor pops and compares them every cycle.
`timescale 1ns/1ps
module tb_multicycle_control;

    localparam int MT = 4;
    localparam int CW = 4;

    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_BAD = 7'b0010011;

    localparam logic [7:0] T_RST = 8'd0, T_IDLE = 8'd1, T_FWAIT = 8'd2, T_FDONE = 8'd3,
                           T_DEC = 8'd4, T_EXEC = 8'd5, T_MWAIT = 8'd6, T_MDONE = 8'd7,
                           T_WB  = 8'd8, T_TRAP = 8'd9;

    typedef struct packed {
        logic [7:0]    tag;
        logic [15:0]   outs;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    opcode = '0;
    logic [2:0]    funct3 = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_read, mem_write, mem_addr_src, ir_write, pc_write, pc_src;
    logic [1:0]    alu_src_b, alu_op;
    logic          reg_write, mem_to_reg, trap;
    logic [2:0]    state;
    logic [CW-1:0] instret;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [15:0]   mon_act;
    logic          cyc_valid = 1'b0;
    logic [CW-1:0] ret_m = '0;
    logic [6:0]    cur_op = '0;
    logic [2:0]    cur_f3 = '0;
    int            checks = 0;
    int            errors = 0;

    multicycle_control #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr_src(mem_addr_src), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .trap(trap), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [2:0] st, input logic rd, input logic wr,
                                       input logic as, input logic irw, input logic pcw,
                                       input logic pcs, input logic [1:0] asb,
                                       input logic [1:0] aop, input logic rw,
                                       input logic m2r, input logic tr);
        return {st, rd, wr, as, irw, pcw, pcs, asb, aop, rw, m2r, tr};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit is_sup(input logic [6:0] op);
        return (op == OP_LD) || (op == OP_SD) || (op == OP_BR) || (op == OP_R);
    endfunction

    function automatic string tag_name(input logic [7:0] t);
        case (t)
            T_RST:   return "reset";
            T_IDLE:  return "idle";
            T_FWAIT: return "fetch_wait";
            T_FDONE: return "fetch_done";
            T_DEC:   return "decode";
            T_EXEC:  return "exec";
            T_MWAIT: return "mem_wait";
            T_MDONE: return "mem_done";
            T_WB:    return "writeback";
            T_TRAP:  return "trap";
            default: return "unknown";
        endcase
    endfunction

    task automatic push_exp(input logic [7:0] tag, input logic [15:0] o);
        exp_t e;
        e.tag  = tag;
        e.outs = o;
        e.cnt  = ret_m;
        exp_q.push_back(e);
        cyc_valid = 1'b1;
    endtask

    // One clock of stimulus plus the control vector expected during it.
    task automatic cyc(input logic [7:0] tag, input logic [15:0] o, input logic rdy, input logic z);
        @(posedge clk);
        #1;
        opcode    = cur_op;
        funct3    = cur_f3;
        mem_ready = rdy;
        zero      = z;
        push_exp(tag, o);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        ret_m = '0;
        mem_ready = rb();
        zero = rb();
        push_exp(T_RST, 16'h0000);
        cyc(T_RST, 16'h0000, rb(), rb());
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_exp(T_IDLE, 16'h0000);
    endtask

    task automatic trap_tail();
        int n;
        n = $urandom_range(2, 5);
        for (int i = 0; i < n; i++) begin
            cur_op = 7'($urandom);
            cur_f3 = 3'($urandom);
            cyc(T_TRAP, mk(3'd6, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1), rb(), rb());
        end
        do_reset();
    endtask

    // Expands one instruction into its cycle sequence from the sequencing rules.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                             input int wf, input int wm, input bit cut_mem);
        int          nf, nm;
        logic        taken;
        logic [15:0] mexp;
        cur_op = op;
        cur_f3 = f3;
        nf = (wf > MT) ? MT + 1 : wf;
        for (int i = 0; i < nf; i++)
            cyc(T_FWAIT, mk(3'd1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0), 1'b0, rb());
        if (wf > MT) begin
            trap_tail();
            return;
        end
        cyc(T_FDONE, mk(3'd1, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0), 1'b1, rb());
        cyc(T_DEC, mk(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0), rb(), rb());
        if (!is_sup(op)) begin
            trap_tail();
            return;
        end
        if (op == OP_R) begin
            cyc(T_EXEC, mk(3'd3, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 0), rb(), rb());
            cyc(T_WB, mk(3'd5, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0), rb(), rb());
            ret_m = ret_m + 1'b1;
            return;
        end
        if (op == OP_BR) begin
            if (f3 != 3'b000 && f3 != 3'b001) begin
                cyc(T_EXEC, mk(3'd3, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0), rb(), z);
                trap_tail();
                return;
            end
            taken = (f3 == 3'b000) ? z : !z;
            cyc(T_EXEC, mk(3'd3, 0, 0, 0, 0, taken, taken, 2'b00, 2'b01, 0, 0, 0), rb(), z);
            ret_m = ret_m + 1'b1;
            return;
        end
        cyc(T_EXEC, mk(3'd3, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0), rb(), rb());
        mexp = mk(3'd4, op == OP_LD, op == OP_SD, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        if (cut_mem) begin
            cyc(T_MWAIT, mexp, 1'b0, rb());
            do_reset();
            return;
        end
        nm = (wm > MT) ? MT + 1 : wm;
        for (int i = 0; i < nm; i++)
            cyc(T_MWAIT, mexp, 1'b0, rb());
        if (wm > MT) begin
            trap_tail();
            return;
        end
        cyc(T_MDONE, mexp, 1'b1, rb());
        if (op == OP_LD) begin
            cyc(T_WB, mk(3'd5, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0), rb(), rb());
        end
        ret_m = ret_m + 1'b1;
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 99);
        if (r < 60) return 0;
        if (r < 90) return $urandom_range(1, MT - 1);
        if (r < 96) return MT;
        return $urandom_range(MT + 1, MT + 3);
    endfunction

    // Monitor: every driven cycle yields one control vector to compare.
    always @(negedge clk) begin
        if (cyc_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: got a cycle with no expected entry at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                mon_act = {state, mem_read, mem_write, mem_addr_src, ir_write, pc_write, pc_src,
                           alu_src_b, alu_op, reg_write, mem_to_reg, trap};
                if (mon_act !== mon_e.outs || instret !== mon_e.cnt) begin
                    errors++;
                    $display("FAIL %s @%0t: got outs=%04h instret=%0d, required outs=%04h instret=%0d",
                             tag_name(mon_e.tag), $time, mon_act, instret, mon_e.outs, mon_e.cnt);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        int         sel;

        do_reset();
        run_instr(OP_LD, 3'b010, 1'b0, 2, 2, 1'b0);
        run_instr(OP_BR, 3'b000, 1'b1, 0, 0, 1'b0);
        run_instr(OP_BR, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(OP_BR, 3'b001, 1'b0, 0, 0, 1'b0);
        run_instr(OP_BR, 3'b001, 1'b1, 0, 0, 1'b0);
        run_instr(OP_SD, 3'b010, 1'b0, 0, 0, 1'b0);
        run_instr(OP_R,  3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(OP_R,  3'b111, 1'b0, MT + 1, 0, 1'b0);
        run_instr(OP_R,  3'b000, 1'b0, MT, 0, 1'b0);
        run_instr(OP_LD, 3'b010, 1'b0, 0, MT, 1'b0);
        run_instr(OP_SD, 3'b010, 1'b0, 0, MT + 1, 1'b0);
        run_instr(OP_BAD, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(OP_BR, 3'b010, 1'b1, 0, 0, 1'b0);
        run_instr(OP_LD, 3'b010, 1'b0, 0, 0, 1'b1);
        run_instr(OP_SD, 3'b010, 1'b0, 1, 0, 1'b1);

        for (int n = 0; n < 250; n++) begin
            sel = $urandom_range(0, 99);
            f3  = 3'($urandom);
            if (sel < 25)      op = OP_LD;
            else if (sel < 50) op = OP_SD;
            else if (sel < 75) begin
                op = OP_BR;
                if ($urandom_range(0, 9) != 0) f3 = 3'($urandom_range(0, 1));
            end
            else if (sel < 95) op = OP_R;
            else begin
                op = 7'($urandom);
                while (is_sup(op)) op = 7'($urandom);
            end
            run_instr(op, f3, rb(), pick_wait(), pick_wait(), ($urandom_range(0, 49) == 0));
        end

        @(negedge clk);
        #1;
        cyc_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
